// File: rtl/regfile_mp_scoreboard_pkg.sv
// Shared types and constants for the multi-port register file with pending-write scoreboard.
// Default widths here match the top module's default parameters.
package regfile_mp_scoreboard_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned NREGS_DEF  = 32;
  localparam int unsigned NUM_RD_DEF = 2;
  localparam int unsigned NUM_WR_DEF = 2;
  localparam int unsigned AW_DEF     = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0] register_num_t;

  localparam register_num_t REG_ZERO = '0;

  typedef struct packed {
    register_num_t       addr;
    logic [XLEN_DEF-1:0] data;
    logic                busy;
  } regfile_rd_port_t;

  typedef struct packed {
    logic                en;
    register_num_t       addr;
    logic [XLEN_DEF-1:0] data;
  } regfile_wr_port_t;

  function automatic logic is_zero_reg(input register_num_t addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard_wr_arb.sv
// Per-register write select across all writeback ports; the highest-index matching port wins.
// Register 0 never receives a write enable.
module regfile_wr_arb #(
  parameter  int unsigned XLEN   = 32,
  parameter  int unsigned NREGS  = 32,
  parameter  int unsigned NUM_WR = 2,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic [NUM_WR-1:0]           wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]   wr_addr_i,
  input  logic [NUM_WR-1:0][XLEN-1:0] wr_data_i,
  output logic [NREGS-1:0]            reg_we_o,
  output logic [NREGS-1:0][XLEN-1:0]  reg_wdata_o,
  output logic [NREGS-1:0]            clr_busy_o
);

  // Ascending port scan so later (higher-index) matches overwrite earlier ones.
  always_comb begin
    reg_we_o    = '0;
    reg_wdata_o = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      for (int unsigned p = 0; p < NUM_WR; p++) begin
        if (wr_en_i[p] && (wr_addr_i[p] == AW'(r))) begin
          reg_we_o[r]    = 1'b1;
          reg_wdata_o[r] = wr_data_i[p];
        end
      end
    end
  end

  assign clr_busy_o = reg_we_o;

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with a per-register busy scoreboard for RAW/WAW detection.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_scoreboard
  import regfile_mp_scoreboard_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned NUM_RD = NUM_RD_DEF,
  parameter  int unsigned NUM_WR = NUM_WR_DEF,
  localparam int unsigned AW     = $clog2(NREGS),
  localparam int unsigned CW     = $clog2(NREGS + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_RD-1:0][AW-1:0]   rd_addr_i,
  output logic [NUM_RD-1:0][XLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]           rd_busy_o,
  input  logic [NUM_WR-1:0]           wr_en_i,
  input  logic [NUM_WR-1:0][AW-1:0]   wr_addr_i,
  input  logic [NUM_WR-1:0][XLEN-1:0] wr_data_i,
  input  logic                        iss_valid_i,
  input  logic [AW-1:0]               iss_rd_i,
  output logic                        iss_ready_o,
  input  logic                        flush_i,
  output logic [CW-1:0]               pending_cnt_o
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           busy_q, busy_d;
  logic [CW-1:0]              pend_q, pend_d;
  logic [NREGS-1:0]           reg_we;
  logic [NREGS-1:0][XLEN-1:0] reg_wdata;
  logic [NREGS-1:0]           clr_busy;
  logic                       iss_zero;
  logic                       iss_fire;

  regfile_wr_arb #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .NUM_WR (NUM_WR)
  ) u_wr_arb (
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i),
    .reg_we_o    (reg_we),
    .reg_wdata_o (reg_wdata),
    .clr_busy_o  (clr_busy)
  );

  // Readiness uses pre-write busy state; register 0 is always ready and never reserved.
  assign iss_zero    = (iss_rd_i == AW'(REG_ZERO));
  assign iss_ready_o = !busy_q[iss_rd_i] || iss_zero;
  assign iss_fire    = iss_valid_i && iss_ready_o && !iss_zero && !flush_i;

  // Next state: writes commit and clear busy, an accepted issue re-sets it, flush clears all.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q & ~clr_busy;
    pend_d = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (reg_we[r]) begin
        regs_d[r] = reg_wdata[r];
      end
    end
    if (iss_fire) begin
      busy_d[iss_rd_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
    for (int unsigned r = 0; r < NREGS; r++) begin
      pend_d = pend_d + CW'(busy_d[r]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '0;
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  assign pending_cnt_o = pend_q;

  // Zero-latency read ports, independent of each other.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      rd_data_o[p] = regs_q[rd_addr_i[p]];
      rd_busy_o[p] = busy_q[rd_addr_i[p]];
`ifdef REGFILE_BYPASS_EN
      if (reg_we[rd_addr_i[p]]) begin
        rd_data_o[p] = reg_wdata[rd_addr_i[p]];
        rd_busy_o[p] = iss_fire && (iss_rd_i == rd_addr_i[p]);
      end
`else
      // Without forwarding, a same-cycle write becomes visible after the edge.
`endif
      if (rd_addr_i[p] == AW'(REG_ZERO)) begin
        rd_data_o[p] = '0;
        rd_busy_o[p] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Scoreboard bench for regfile_mp_scoreboard: driver pushes model expectations, monitor compares.
// Honours REGFILE_BYPASS_EN in the reference model.
module tb_regfile_mp_scoreboard;
  import regfile_mp_scoreboard_pkg::*;

  localparam int unsigned XLEN   = XLEN_DEF;
  localparam int unsigned NREGS  = NREGS_DEF;
  localparam int unsigned NUM_RD = NUM_RD_DEF;
  localparam int unsigned NUM_WR = NUM_WR_DEF;
  localparam int unsigned AW     = AW_DEF;
  localparam int unsigned CW     = $clog2(NREGS + 1);

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NUM_RD-1:0][AW-1:0]   rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]           rd_busy;
  logic [NUM_WR-1:0]           wr_en;
  logic [NUM_WR-1:0][AW-1:0]   wr_addr;
  logic [NUM_WR-1:0][XLEN-1:0] wr_data;
  logic                        iss_valid;
  logic [AW-1:0]               iss_rd;
  logic                        iss_ready;
  logic                        flush;
  logic [CW-1:0]               pending_cnt;

  always #5 clk = ~clk;

  regfile_mp_scoreboard dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .rd_busy_o     (rd_busy),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .iss_valid_i   (iss_valid),
    .iss_rd_i      (iss_rd),
    .iss_ready_o   (iss_ready),
    .flush_i       (flush),
    .pending_cnt_o (pending_cnt)
  );

  typedef struct {
    logic [NUM_RD-1:0][XLEN-1:0] data;
    logic [NUM_RD-1:0]           busy;
    logic                        ready;
    int                          pend;
    int                          fport;   // -1: no spec-constant data check
    logic [XLEN-1:0]             fdata;
    int                          fbusy;   // -1: no spec-constant busy check
    int                          fready;  // -1: no spec-constant ready check
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: architectural register values and outstanding-write flags.
  logic [XLEN-1:0] m_regs[NREGS];
  bit              m_busy[NREGS];

  // Stimulus for the next cycle.
  bit               s_rst, s_flush, s_iss_v;
  register_num_t    s_iss_rd;
  register_num_t    s_ra[NUM_RD];
  regfile_wr_port_t s_wp[NUM_WR];

  task automatic idle();
    s_rst = 0; s_flush = 0; s_iss_v = 0; s_iss_rd = '0;
    for (int p = 0; p < NUM_RD; p++) s_ra[p] = '0;
    for (int w = 0; w < NUM_WR; w++) s_wp[w] = '0;
  endtask

  task automatic step(input int fport = -1, input logic [XLEN-1:0] fdata = '0,
                      input int fbusy = -1, input int fready = -1);
    exp_t e;
    bit   acc;
    int   cnt;
    @(posedge clk); #1;
    rst = s_rst; flush = s_flush; iss_valid = s_iss_v; iss_rd = s_iss_rd;
    for (int p = 0; p < NUM_RD; p++) rd_addr[p] = s_ra[p];
    for (int w = 0; w < NUM_WR; w++) begin
      wr_en[w] = s_wp[w].en; wr_addr[w] = s_wp[w].addr; wr_data[w] = s_wp[w].data;
    end
    e.ready = (s_iss_rd == 0) || !m_busy[s_iss_rd];
    acc = s_iss_v && e.ready && !s_flush && (s_iss_rd != 0);
    cnt = 0;
    for (int r = 0; r < NREGS; r++) cnt += int'(m_busy[r]);
    e.pend = cnt;
    for (int p = 0; p < NUM_RD; p++) begin
      if (s_ra[p] == 0) begin
        e.data[p] = '0; e.busy[p] = 1'b0;
      end else begin
        e.data[p] = m_regs[s_ra[p]]; e.busy[p] = m_busy[s_ra[p]];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          if (s_wp[w].en && s_wp[w].addr == s_ra[p]) begin
            e.data[p] = s_wp[w].data;
            e.busy[p] = acc && (s_iss_rd == s_ra[p]);
          end
        end
`endif
      end
    end
    e.fport = fport; e.fdata = fdata; e.fbusy = fbusy; e.fready = fready;
    exp_q.push_back(e);
    if (s_rst) begin
      for (int r = 0; r < NREGS; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (s_wp[w].en && s_wp[w].addr != 0) begin
          m_regs[s_wp[w].addr] = s_wp[w].data;
          m_busy[s_wp[w].addr] = 0;
        end
      end
      if (acc) m_busy[s_iss_rd] = 1;
      if (s_flush) for (int r = 0; r < NREGS; r++) m_busy[r] = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, req);
    end
  endtask

  // Monitor: outputs are stable at the falling edge for the cycle that was driven.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int p = 0; p < NUM_RD; p++) begin
        chk($sformatf("rd_data[%0d]", p), 64'(rd_data[p]), 64'(e.data[p]));
        chk($sformatf("rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(e.busy[p]));
      end
      chk("iss_ready", 64'(iss_ready), 64'(e.ready));
      chk("pending_cnt", 64'(pending_cnt), 64'(e.pend));
      if (e.fport >= 0) begin
        chk("spec_data", 64'(rd_data[e.fport]), 64'(e.fdata));
        if (e.fbusy >= 0) chk("spec_busy", 64'(rd_busy[e.fport]), 64'(e.fbusy));
      end
      if (e.fready >= 0) chk("spec_ready", 64'(iss_ready), 64'(e.fready));
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; iss_valid = 1'b0; iss_rd = '0;
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    for (int r = 0; r < NREGS; r++) begin m_regs[r] = '0; m_busy[r] = 0; end
    repeat (2) @(posedge clk);

    // Random writes and issues, then a reset cycle clears everything.
    for (int i = 0; i < 6; i++) begin
      idle();
      s_iss_v = 1; s_iss_rd = register_num_t'($urandom_range(1, NREGS - 1));
      s_wp[0] = '{en: 1'b1, addr: register_num_t'($urandom_range(1, NREGS - 1)), data: $urandom};
      step();
    end
    idle(); s_rst = 1; s_iss_v = 1; s_iss_rd = 5'd3; s_flush = 0;
    s_wp[1] = '{en: 1'b1, addr: 5'd10, data: 32'h5555};
    step();
    for (int a = 0; a < 8; a++) begin
      idle(); s_ra[0] = register_num_t'(a * 4 + 2); s_ra[1] = register_num_t'(a * 4 + 3);
      step(0, '0, 0);
    end

    // Issue 5, writeback three cycles later.
    idle(); s_iss_v = 1; s_iss_rd = 5'd5; step(-1, '0, -1, 1);
    idle(); s_ra[0] = 5'd5;
    repeat (3) step(0, '0, 1);
    s_wp[0] = '{en: 1'b1, addr: 5'd5, data: 32'hDEADBEEF};
    step(0, '0, 1);
    idle(); s_ra[0] = 5'd5; step(0, 32'hDEADBEEF, 0);

    // Same-address dual write and a write to register 0.
    idle();
    s_wp[0] = '{en: 1'b1, addr: 5'd7, data: 32'h11};
    s_wp[1] = '{en: 1'b1, addr: 5'd7, data: 32'h22};
    step();
    idle(); s_ra[0] = 5'd7; s_wp[0] = '{en: 1'b1, addr: 5'd0, data: 32'hFFFFFFFF}; step(0, 32'h22);
    idle(); s_ra[0] = 5'd0; s_ra[1] = 5'd7; step(0, '0, 0);

    // WAW stall on register 9: held request accepted the cycle after writeback.
    idle(); s_iss_v = 1; s_iss_rd = 5'd9; step(-1, '0, -1, 1);
    step(-1, '0, -1, 0);
    step(-1, '0, -1, 0);
    s_wp[1] = '{en: 1'b1, addr: 5'd9, data: 32'h99}; step(-1, '0, -1, 0);
    s_wp[1] = '0; s_ra[0] = 5'd9; step(0, 32'h99, 0, 1);
    idle(); s_ra[0] = 5'd9; step(0, 32'h99, 1);

    // Flush with a same-cycle write.
    idle(); s_iss_v = 1;
    s_iss_rd = 5'd3; step();
    s_iss_rd = 5'd4; step();
    s_iss_rd = 5'd6; step();
    idle(); s_flush = 1; s_iss_v = 1; s_iss_rd = 5'd8;
    s_wp[0] = '{en: 1'b1, addr: 5'd4, data: 32'h44}; step();
    idle(); s_ra[0] = 5'd4; s_ra[1] = 5'd3; step(0, 32'h44, 0);
    s_ra[0] = 5'd6; s_ra[1] = 5'd8; step(0, '0, 0);

    // Same-cycle write and read of register 12.
    idle(); s_wp[0] = '{en: 1'b1, addr: 5'd12, data: 32'h1234}; step();
    s_wp[0].data = 32'hABCD; s_ra[0] = 5'd12;
`ifdef REGFILE_BYPASS_EN
    step(0, 32'hABCD, 0);
`else
    step(0, 32'h1234, 0);
`endif
    idle(); s_ra[0] = 5'd12; step(0, 32'hABCD, 0);

    // Randomized traffic with narrow address ranges to force collisions.
    for (int i = 0; i < 3000; i++) begin
      idle();
      s_rst   = ($urandom_range(0, 127) == 0);
      s_flush = ($urandom_range(0, 15) == 0);
      s_iss_v = $urandom_range(0, 1) != 0;
      s_iss_rd = register_num_t'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : NREGS - 1));
      for (int p = 0; p < NUM_RD; p++) s_ra[p] = register_num_t'($urandom_range(0, 15));
      for (int w = 0; w < NUM_WR; w++) begin
        s_wp[w].en   = $urandom_range(0, 2) == 0;
        s_wp[w].addr = register_num_t'($urandom_range(0, 15));
        s_wp[w].data = $urandom;
      end
      step();
    end

    idle(); step();
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
      $fatal(1, "scoreboard not drained");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
